// File: rtl/decoder_rr_arbiter_if.sv
// Handshake bundle between requesters and the decoder-tree arbiter.
// The arbiter side uses modport slave; requesters/bench use master.
interface decoder_rr_arbiter_if #(
  parameter int N_REQ = 16,
  parameter int SEL_W = 4
);
  logic [N_REQ-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic             en416;
  logic             en38;
  logic             en24;
  logic             grant_valid;
  logic [N_REQ-1:0] grant;

  modport master (
    output req,
    output done,
    input  sel,
    input  en416,
    input  en38,
    input  en24,
    input  grant_valid,
    input  grant
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output en416,
    output en38,
    output en24,
    output grant_valid,
    output grant
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of the 4-to-16 decoder tree, break-before-make.
// Define DECODER_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
module decoder_rr_arbiter #(
  parameter int N_REQ = 16,
  parameter int SEL_W = 4
`ifdef DECODER_ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 8
`endif
) (
  input logic clk,
  input logic rst,
  decoder_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_n;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_n;
  logic             gv_q;
  logic             gv_n;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             rel;

`ifdef DECODER_ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic [7:0] hold_n;
  logic       expired;

  assign expired = (hold_q == 8'(MAX_HOLD - 1));
`endif

  // rotating priority search starting at ptr, lowest offset wins
  always_comb begin
    logic [SEL_W-1:0] idx;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr_q + SEL_W'(i);
      if (bus.req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

`ifdef DECODER_ARB_TIMEOUT_EN
  assign rel = bus.done | ~bus.req[sel_q] | expired;
`else
  assign rel = bus.done | ~bus.req[sel_q];
`endif

  // next-state, next owner and pointer update
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    gv_n    = gv_q;
`ifdef DECODER_ARB_TIMEOUT_EN
    hold_n  = hold_q;
`endif
    unique case (state_q)
      BUSY: begin
        if (rel) begin
          state_n = GAP;
          gv_n    = 1'b0;
        end
`ifdef DECODER_ARB_TIMEOUT_EN
        else begin
          hold_n = hold_q + 8'd1;
        end
`endif
      end
      IDLE, GAP: begin
        if (any) begin
          state_n = BUSY;
          sel_n   = win;
          ptr_n   = win + SEL_W'(1);
          gv_n    = 1'b1;
`ifdef DECODER_ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else begin
          state_n = IDLE;
          gv_n    = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        gv_n    = 1'b0;
      end
    endcase
  end

  // state and owner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gv_q    <= 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      ptr_q   <= ptr_n;
      gv_q    <= gv_n;
`ifdef DECODER_ARB_TIMEOUT_EN
      hold_q  <= hold_n;
`endif
    end
  end

  assign bus.sel         = sel_q;
  assign bus.grant_valid = gv_q;
  assign bus.en416       = gv_q;
  assign bus.en38        = gv_q;
  assign bus.en24        = gv_q;
  assign bus.grant       = gv_q ? (N_REQ'(1) << sel_q) : '0;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: reset, rotation, wrap,
// break-before-make gaps, reset mid-grant and hold/timeout behaviour.
module tb_decoder_rr_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(string tag, logic v, logic [3:0] s,
                         logic [15:0] g);
    chk({tag, ".gv"}, 32'(bus.grant_valid), 32'(v));
    chk({tag, ".en416"}, 32'(bus.en416), 32'(v));
    chk({tag, ".en38"}, 32'(bus.en38), 32'(v));
    chk({tag, ".en24"}, 32'(bus.en24), 32'(v));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
  endtask

  int rr_idx [5] = '{0, 1, 15, 0, 1};

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    tick();
    tick();
    chk_out("reset", 1'b0, 4'd0, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("idle", 1'b0, 4'd0, 16'h0000);
    end

    bus.req = 16'h0020;
    tick();
    chk_out("single", 1'b1, 4'd5, 16'h0020);
    tick();
    chk_out("single_hold", 1'b1, 4'd5, 16'h0020);
    bus.done = 1'b1;
    tick();
    chk_out("single_rel", 1'b0, 4'd5, 16'h0000);
    bus.done = 1'b0;
    bus.req  = '0;
    tick();
    chk_out("single_idle", 1'b0, 4'd5, 16'h0000);

    rst = 1'b1;
    tick();
    chk_out("reset2", 1'b0, 4'd0, 16'h0000);
    rst = 1'b0;

    bus.req = 16'h8003;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        bus.done = 1'b1;
        tick();
        chk_out("rr_gap", 1'b0, 4'(rr_idx[i-1]), 16'h0000);
        bus.done = 1'b0;
      end
      tick();
      chk_out("rr_grant", 1'b1, 4'(rr_idx[i]),
              16'h0001 << rr_idx[i]);
    end

    bus.done = 1'b1;
    bus.req  = '0;
    tick();
    chk_out("rr_end", 1'b0, 4'd1, 16'h0000);
    bus.done = 1'b0;
    tick();
    chk_out("rr_idle", 1'b0, 4'd1, 16'h0000);

    bus.req = 16'h4000;
    tick();
    chk_out("grant14", 1'b1, 4'd14, 16'h4000);
    bus.req  = 16'h4001;
    bus.done = 1'b1;
    tick();
    chk_out("rel14", 1'b0, 4'd14, 16'h0000);
    bus.done = 1'b0;
    tick();
    chk_out("wrap0", 1'b1, 4'd0, 16'h0001);
    bus.done = 1'b1;
    tick();
    chk_out("rel0", 1'b0, 4'd0, 16'h0000);
    bus.done = 1'b0;
    tick();
    chk_out("wrap14", 1'b1, 4'd14, 16'h4000);

    bus.req = 16'h0001;
    tick();
    chk_out("reqdrop", 1'b0, 4'd14, 16'h0000);
    tick();
    chk_out("after_drop", 1'b1, 4'd0, 16'h0001);

    bus.req  = 16'h0200;
    bus.done = 1'b1;
    tick();
    chk_out("both_rel", 1'b0, 4'd0, 16'h0000);
    tick();
    chk_out("gap_done_ign", 1'b1, 4'd9, 16'h0200);
    tick();
    chk_out("rel9", 1'b0, 4'd9, 16'h0000);
    bus.req = '0;
    tick();
    chk_out("idle_done", 1'b0, 4'd9, 16'h0000);
    tick();
    chk_out("idle_done2", 1'b0, 4'd9, 16'h0000);
    bus.done = 1'b0;

    bus.req = 16'h0200;
    tick();
    chk_out("own9", 1'b1, 4'd9, 16'h0200);
    bus.req = 16'h0201;
    tick();
    chk_out("no_preempt", 1'b1, 4'd9, 16'h0200);
    rst = 1'b1;
    tick();
    chk_out("rst_mid", 1'b0, 4'd0, 16'h0000);
    rst = 1'b0;
    tick();
    chk_out("ptr_reset", 1'b1, 4'd0, 16'h0001);

    bus.req = '0;
    tick();
    tick();
    chk_out("pre_hold", 1'b0, 4'd0, 16'h0000);

    bus.req = 16'h0008;
    tick();
    chk_out("hold_grant", 1'b1, 4'd3, 16'h0008);
`ifdef DECODER_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out("hold_on", 1'b1, 4'd3, 16'h0008);
    end
    tick();
    chk_out("timeout_gap", 1'b0, 4'd3, 16'h0000);
    tick();
    chk_out("timeout_regrant", 1'b1, 4'd3, 16'h0008);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_out("hold_on", 1'b1, 4'd3, 16'h0008);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
